// File: rtl/alu_issue_if.sv
// Handshake bundle between the fetch/regfile side, the ALU issue stage and execute.
// The issue stage takes the slave modport; the producer/consumer side takes master.
interface alu_issue_if #(
  parameter int unsigned ISSUE_CNT_W = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            instr;
  logic [31:0]            rs1_data;
  logic [31:0]            rs2_data;
  logic                   flush;
  logic                   ex_valid;
  logic                   ex_ready;
  logic [31:0]            ex_a;
  logic [31:0]            ex_b;
  logic [3:0]             ex_alucon;
  logic [4:0]             ex_rd;
  logic                   ex_we;
  logic                   illegal;
  logic [ISSUE_CNT_W-1:0] issue_count;

  modport slave (
    input  in_valid, instr, rs1_data, rs2_data, flush, ex_ready,
    output in_ready, ex_valid, ex_a, ex_b, ex_alucon, ex_rd, ex_we, illegal, issue_count
  );

  modport master (
    output in_valid, instr, rs1_data, rs2_data, flush, ex_ready,
    input  in_ready, ex_valid, ex_a, ex_b, ex_alucon, ex_rd, ex_we, illegal, issue_count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ALU decode/issue stage: decodes R/I-type ALU ops, conditions operands and
// issues them through a 2-entry skid buffer (main drives ex_*, skid holds overflow).
module alu_issue_stage #(
  parameter int unsigned ISSUE_CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_issue_if.slave   bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned RD_W  = 5;
  localparam int unsigned SHW   = 5;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_AND = 4'b0100;
  localparam logic [OP_W-1:0] OP_SLL = 4'b0101;
  localparam logic [OP_W-1:0] OP_SRL = 4'b0110;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [OP_W-1:0] op;
    logic [RD_W-1:0] rd;
    logic            we;
  } ent_t;

  ent_t                   main_q, main_d, skid_q, skid_d, dec;
  logic                   main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic                   illegal_q, illegal_d;
  logic [ISSUE_CNT_W-1:0] cnt_q, cnt_d;
  logic                   dec_ok, is_r, is_i, f7_zero;
  logic [XLEN-1:0]        src_b;
  logic                   accept, push, consume;

  // Instruction decode and operand selection for the incoming word.
  always_comb begin
    is_r    = (bus.instr[6:0] == OPC_R);
    is_i    = (bus.instr[6:0] == OPC_I);
    f7_zero = (bus.instr[31:25] == F7_ZERO);
    src_b   = is_r ? bus.rs2_data : {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
    dec_ok  = 1'b0;
    dec.a   = bus.rs1_data;
    dec.b   = src_b;
    dec.op  = OP_ADD;
    dec.rd  = bus.instr[11:7];
    dec.we  = |bus.instr[11:7];
    if (is_r || is_i) begin
      case (bus.instr[14:12])
        3'b000: begin
          if (is_i || f7_zero) begin
            dec.op = OP_ADD;
            dec_ok = 1'b1;
          end else if (bus.instr[31:25] == F7_ALT) begin
            dec.op = OP_SUB;
            dec_ok = 1'b1;
          end
        end
        3'b100: begin dec.op = OP_XOR; dec_ok = is_i || f7_zero; end
        3'b110: begin dec.op = OP_OR;  dec_ok = is_i || f7_zero; end
        3'b111: begin dec.op = OP_AND; dec_ok = is_i || f7_zero; end
        3'b001: begin dec.op = OP_SLL; dec_ok = f7_zero; end
        3'b101: begin dec.op = OP_SRL; dec_ok = f7_zero; end
        default: dec_ok = 1'b0;
      endcase
    end
    // The ALU shifts by all of B, so only the 5-bit shamt may reach it.
    if (dec.op == OP_SLL || dec.op == OP_SRL) begin
      dec.b = {{(XLEN-SHW){1'b0}}, src_b[SHW-1:0]};
    end
  end

  assign accept  = bus.in_valid && !skid_v_q;
  assign push    = accept && dec_ok && !bus.flush;
  assign consume = main_v_q && bus.ex_ready;

  // Skid buffer next state; skid is empty whenever a push can occur.
  always_comb begin
    main_d    = main_q;
    skid_d    = skid_q;
    main_v_d  = main_v_q;
    skid_v_d  = skid_v_q;
    illegal_d = accept && !dec_ok && !bus.flush;
    cnt_d     = consume ? cnt_q + ISSUE_CNT_W'(1) : cnt_q;
    if (bus.flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (consume) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (push) begin
        main_d = dec;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (push) begin
      if (!main_v_q) begin
        main_d   = dec;
        main_v_d = 1'b1;
      end else begin
        skid_d   = dec;
        skid_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q    <= '0;
      skid_q    <= '0;
      main_v_q  <= 1'b0;
      skid_v_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      main_q    <= main_d;
      skid_q    <= skid_d;
      main_v_q  <= main_v_d;
      skid_v_q  <= skid_v_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready    = !skid_v_q;
  assign bus.ex_valid    = main_v_q;
  assign bus.ex_a        = main_q.a;
  assign bus.ex_b        = main_q.b;
  assign bus.ex_alucon   = main_q.op;
  assign bus.ex_rd       = main_q.rd;
  assign bus.ex_we       = main_q.we;
  assign bus.illegal     = illegal_q;
  assign bus.issue_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if #(.ISSUE_CNT_W(32)) bus ();
  alu_issue_stage #(.ISSUE_CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
  } ent_t;

  int unsigned tests = 0;
  int unsigned fails = 0;

  ent_t        mq[$];
  logic        m_illegal = 1'b0;
  logic [31:0] m_count = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the ISA rules: returns op code, or ok=0 for illegal.
  function automatic void ref_dec(input logic [31:0] ins, input logic [31:0] r1,
                                  input logic [31:0] r2, output logic ok, output ent_t e);
    logic [6:0] opc = ins[6:0];
    logic [6:0] f7  = ins[31:25];
    int         f3  = int'(ins[14:12]);
    logic       rt  = (opc == 7'h33);
    logic       it  = (opc == 7'h13);
    int         op  = -1;
    logic [31:0] bsrc = rt ? r2 : 32'($signed(ins) >>> 20);
    if (rt || it) begin
      case (f3)
        0: op = (it || f7 == 7'h00) ? 0 : ((f7 == 7'h20) ? 1 : -1);
        4: op = 2;
        6: op = 3;
        7: op = 4;
        1: op = 5;
        5: op = 6;
        default: op = -1;
      endcase
      if (op >= 2 && op <= 4 && rt && f7 != 7'h00) op = -1;
      if ((op == 5 || op == 6) && f7 != 7'h00) op = -1;
    end
    ok   = (op >= 0);
    e.a  = r1;
    e.b  = (op == 5 || op == 6) ? (bsrc & 32'h1F) : bsrc;
    e.op = ok ? 4'(op) : 4'd0;
    e.rd = ins[11:7];
    e.we = (ins[11:7] != 5'd0);
  endfunction

  // Reference model: a FIFO of at most two decoded entries.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_illegal = 1'b0;
        m_count   = 32'd0;
      end else begin
        logic acc, ok;
        ent_t e;
        acc = bus.in_valid && (mq.size() < 2);
        ref_dec(bus.instr, bus.rs1_data, bus.rs2_data, ok, e);
        if (mq.size() > 0 && bus.ex_ready) begin
          void'(mq.pop_front());
          m_count = m_count + 32'd1;
        end
        m_illegal = acc && !ok && !bus.flush;
        if (bus.flush) mq.delete();
        else if (acc && ok) mq.push_back(e);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
      chk("ex_valid", 32'(bus.ex_valid), 32'(mq.size() > 0));
      chk("illegal", 32'(bus.illegal), 32'(m_illegal));
      chk("issue_count", bus.issue_count, m_count);
      if (mq.size() > 0) begin
        chk("ex_a", bus.ex_a, mq[0].a);
        chk("ex_b", bus.ex_b, mq[0].b);
        chk("ex_alucon", 32'(bus.ex_alucon), 32'(mq[0].op));
        chk("ex_rd", 32'(bus.ex_rd), 32'(mq[0].rd));
        chk("ex_we", 32'(bus.ex_we), 32'(mq[0].we));
      end
    end
  end

  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] r1,
                     input logic [31:0] r2, input logic er, input logic fl);
    bus.in_valid = iv;
    bus.instr    = ins;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
    bus.ex_ready = er;
    bus.flush    = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ADDI = 32'hFFF00293;
  localparam logic [31:0] I_SLLI = 32'h00309313;
  localparam logic [31:0] I_SRL  = 32'h0020D3B3;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_XORI = 32'h0FF0C213;

  initial begin
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_count", bus.issue_count, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_ex_a", bus.ex_a, 32'd0);
    chk("rst_ex_b", bus.ex_b, 32'd0);
    chk("rst_alucon", 32'(bus.ex_alucon), 32'd0);
    chk("rst_rd", 32'(bus.ex_rd), 32'd0);
    chk("rst_we", 32'(bus.ex_we), 32'd0);
    rst_n = 1'b1;
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Directed decode checks, each consumed on the following edge.
    cyc(1'b1, I_ADD, 32'd5, 32'd7, 1'b1, 1'b0);
    chk("add_valid", 32'(bus.ex_valid), 32'd1);
    chk("add_alucon", 32'(bus.ex_alucon), 32'h0);
    chk("add_a", bus.ex_a, 32'd5);
    chk("add_b", bus.ex_b, 32'd7);
    chk("add_rd", 32'(bus.ex_rd), 32'd3);
    chk("add_we", 32'(bus.ex_we), 32'd1);
    cyc(1'b1, I_SUB, 32'd9, 32'd4, 1'b1, 1'b0);
    chk("sub_alucon", 32'(bus.ex_alucon), 32'h1);
    cyc(1'b1, I_ADDI, 32'd3, 32'd0, 1'b1, 1'b0);
    chk("addi_alucon", 32'(bus.ex_alucon), 32'h0);
    chk("addi_b", bus.ex_b, 32'hFFFFFFFF);
    chk("addi_rd", 32'(bus.ex_rd), 32'd5);
    cyc(1'b1, I_SLLI, 32'd1, 32'd0, 1'b1, 1'b0);
    chk("slli_alucon", 32'(bus.ex_alucon), 32'h5);
    chk("slli_b", bus.ex_b, 32'd3);
    cyc(1'b1, I_SRL, 32'd1, 32'hFFFFFFE4, 1'b1, 1'b0);
    chk("srl_alucon", 32'(bus.ex_alucon), 32'h6);
    chk("srl_b", bus.ex_b, 32'd4);
    cyc(1'b1, I_SLT, 32'd1, 32'd2, 1'b1, 1'b0);
    chk("slt_illegal", 32'(bus.illegal), 32'd1);
    chk("slt_ex_valid", 32'(bus.ex_valid), 32'd0);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("slt_pulse_end", 32'(bus.illegal), 32'd0);
    chk("count_5", bus.issue_count, 32'd5);

    // Asynchronous reset with both entries held.
    cyc(1'b1, I_ADD, 32'd1, 32'd2, 1'b0, 1'b0);
    cyc(1'b1, I_SUB, 32'd3, 32'd4, 1'b0, 1'b0);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_count", bus.issue_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Backpressure: third instruction must be held off.
    cyc(1'b1, I_ADD, 32'd11, 32'd22, 1'b0, 1'b0);
    chk("bp1_a", bus.ex_a, 32'd11);
    chk("bp1_in_ready", 32'(bus.in_ready), 32'd1);
    cyc(1'b1, I_XORI, 32'd33, 32'd0, 1'b0, 1'b0);
    chk("bp2_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp2_a", bus.ex_a, 32'd11);
    cyc(1'b1, I_SUB, 32'd44, 32'd55, 1'b0, 1'b0);
    chk("bp3_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp3_alucon", 32'(bus.ex_alucon), 32'h0);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("drain_a", bus.ex_a, 32'd33);
    chk("drain_b", bus.ex_b, 32'h000000FF);
    chk("drain_alucon", 32'(bus.ex_alucon), 32'h2);
    chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("drain_empty", 32'(bus.ex_valid), 32'd0);
    chk("drain_count", bus.issue_count, 32'd2);

    // Flush with both entries held and input pending.
    cyc(1'b1, I_ADD, 32'd1, 32'd1, 1'b0, 1'b0);
    cyc(1'b1, I_ADD, 32'd2, 32'd2, 1'b0, 1'b0);
    cyc(1'b1, I_SLT, 32'd3, 32'd3, 1'b0, 1'b1);
    chk("flush_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_illegal", 32'(bus.illegal), 32'd0);
    // Flush with an accepted illegal input and a same-cycle consume.
    cyc(1'b1, I_ADD, 32'd4, 32'd4, 1'b0, 1'b0);
    cyc(1'b1, I_SLT, 32'd5, 32'd5, 1'b1, 1'b1);
    chk("flush2_illegal", 32'(bus.illegal), 32'd0);
    chk("flush2_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush2_count", bus.issue_count, 32'd3);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      int          s;
      ins = $urandom;
      s = int'($urandom_range(0, 9));
      ins[6:0] = (s < 4) ? 7'h33 : ((s < 8) ? 7'h13 : ins[6:0]);
      s = int'($urandom_range(0, 3));
      ins[31:25] = (s == 0 || s == 2) ? 7'h00 : ((s == 1) ? 7'h20 : ins[31:25]);
      cyc($urandom_range(0, 3) != 0, ins, $urandom, $urandom,
          $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("final_empty", 32'(bus.ex_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
